// File: rtl/sl_transmitter.sv
// sl_transmitter
//   Serial-Link two-wire transmitter. Serialises an 8/16/24/32-bit word MSB
//   first onto two active-low strobe lines: a low pulse on sl0 is a 0 bit,
//   a low pulse on sl1 is a 1 bit, and both lines low together ends the word.
//
//   Optional feature macro: SL_TX_PARITY_EN
//     defined   -> one odd-parity bit (~^ of the data bits) follows the data
//     undefined -> stop marker follows the last data bit directly
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   enable   in   request to send, sampled only while ready=1 and idle
//   mode[1:0] in  word length 00=8, 01=16, 10=24, 11=32 bits
//   data[31:0] in word to send, low 8*(mode+1) bits used
//   ready    out  idle and able to accept a word
//   sl0      out  zero-strobe line, active low, idle high
//   sl1      out  one-strobe line, active low, idle high
//
// State table
//   IDLE      | waiting for enable, lines high, ready high
//   BIT_LOW   | current bit's strobe held low for PULSE_CYCLES
//   BIT_HIGH  | both lines high for GAP_CYCLES between pulses
//   STOP_LOW  | both lines low (end of word) for PULSE_CYCLES
//   STOP_HIGH | both lines high for GAP_CYCLES before returning idle

module sl_transmitter #(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [31:0] data,
    output logic        ready,
    output logic        sl0,
    output logic        sl1
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BIT_LOW   = 3'd1,
        BIT_HIGH  = 3'd2,
        STOP_LOW  = 3'd3,
        STOP_HIGH = 3'd4
    } state_t;

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [5:0]    bit_cnt;
    logic [32:0]   shreg;
    logic          tc;
    logic          capture;

    logic [5:0]    n_data;
    logic [5:0]    shamt;
    logic [32:0]   load_shreg;
    logic [5:0]    load_cnt;

    logic          ready_d, sl0_d, sl1_d;

    assign tc      = (timer == '0);
    assign capture = (state == IDLE) && enable && ready;

    // Word is left-aligned so the bit on the wire is always shreg[32]; the
    // parity bit, when present, sits directly below the last data bit.
    always_comb begin
        n_data     = 6'(({4'b0000, mode} + 6'd1) << 3);
        shamt      = 6'd32 - n_data;
        load_shreg = {data << shamt, 1'b0};
        load_cnt   = n_data;
`ifdef SL_TX_PARITY_EN
        load_shreg = load_shreg
                   | (33'(~^(data & (32'hFFFF_FFFF >> shamt))) << shamt);
        load_cnt   = n_data + 6'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                case (state_nxt)
                    BIT_LOW, STOP_LOW:   timer <= PULSE_LOAD;
                    BIT_HIGH, STOP_HIGH: timer <= GAP_LOAD;
                    default:             timer <= '0;
                endcase
            end else if (!tc) begin
                timer <= timer - TW'(1);
            end
            if (capture) begin
                shreg   <= load_shreg;
                bit_cnt <= load_cnt;
            end else if (state == BIT_LOW && tc) begin
                shreg   <= {shreg[31:0], 1'b0};
                bit_cnt <= bit_cnt - 6'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (capture) state_nxt = BIT_LOW;
            BIT_LOW:   if (tc)      state_nxt = BIT_HIGH;
            BIT_HIGH:  if (tc)      state_nxt = (bit_cnt != '0) ? BIT_LOW : STOP_LOW;
            STOP_LOW:  if (tc)      state_nxt = STOP_HIGH;
            STOP_HIGH: if (tc)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so the
    // lines trail the state register by one clock.
    always_comb begin
        ready_d = (state == IDLE);
        sl0_d   = 1'b1;
        sl1_d   = 1'b1;
        case (state)
            BIT_LOW: begin
                sl0_d = shreg[32];
                sl1_d = ~shreg[32];
            end
            STOP_LOW: begin
                sl0_d = 1'b0;
                sl1_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready <= 1'b1;
            sl0   <= 1'b1;
            sl1   <= 1'b1;
        end else begin
            ready <= ready_d;
            sl0   <= sl0_d;
            sl1   <= sl1_d;
        end
    end

endmodule

// File: tb/tb_sl_transmitter.sv
module tb_sl_transmitter;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        ready;
    logic        sl0;
    logic        sl1;

    int checks   = 0;
    int failures = 0;

    // expected {ready, sl0, sl1} for each successive clock
    logic [2:0] exp_q[$];

    sl_transmitter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .mode    (mode),
        .data    (data),
        .ready   (ready),
        .sl0     (sl0),
        .sl1     (sl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: {ready,sl0,sl1} got=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic push_frame(input logic [1:0] m, input logic [31:0] d);
        int nd;
        int ones;
        logic b;
        nd   = 8 * (int'(m) + 1);
        ones = 0;
        for (int k = nd - 1; k >= 0; k--) begin
            b = d[k];
            if (b) ones++;
            exp_q.push_back({1'b0, b, ~b});
            exp_q.push_back(3'b011);
        end
`ifdef SL_TX_PARITY_EN
        b = ((ones % 2) == 0);
        exp_q.push_back({1'b0, b, ~b});
        exp_q.push_back(3'b011);
`endif
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b111);
    endtask

    task automatic step_check(input string tag);
        logic [2:0] e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got=%b", tag, {ready, sl0, sl1});
        end else begin
            e = exp_q.pop_front();
            check(tag, {ready, sl0, sl1}, e);
        end
    endtask

    task automatic run_n(input string tag, input int n);
        for (int i = 0; i < n; i++) step_check(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) step_check(tag);
    endtask

    // one-edge enable pulse; inputs scrambled right after capture
    task automatic start_frame(input string tag, input logic [1:0] m, input logic [31:0] d);
        @(negedge clk);
        mode   = m;
        data   = d;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        mode   = ~m;
        data   = ~d;
        check({tag, "_capture"}, {ready, sl0, sl1}, 3'b111);
        push_frame(m, d);
    endtask

    initial begin
        int n1;
        reset_n = 1'b0;
        enable  = 1'b0;
        mode    = 2'b00;
        data    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {ready, sl0, sl1}, 3'b111);
        reset_n = 1'b1;
        push_idle(4);
        drain("idle_after_reset");

        start_frame("f16", 2'b01, 32'd2134);
        drain("f16");

        start_frame("f8", 2'b00, 32'hFFFF_FFA5);
        drain("f8");

        // back-to-back with enable held, dropped partway into the second frame
        @(negedge clk);
        mode   = 2'b11;
        data   = 32'h8000_0001;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_capture", {ready, sl0, sl1}, 3'b111);
        push_frame(2'b11, 32'h8000_0001);
        n1 = exp_q.size();
        push_idle(1);
        push_frame(2'b11, 32'h8000_0001);
        run_n("b2b", n1 + 1 + 10);
        enable = 1'b0;
        drain("b2b_second");
        push_idle(6);
        drain("b2b_no_recapture");

        // reset asserted while bit 5 of a 24-bit frame is on the line
        start_frame("f24", 2'b10, 32'h00C3_5A96);
        run_n("f24_pre_abort", 11);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_abort", {ready, sl0, sl1}, 3'b111);
        exp_q.delete();
        reset_n = 1'b1;
        push_idle(6);
        drain("post_abort_idle");

        start_frame("f24b", 2'b10, 32'h5A3C_E71B);
        drain("f24b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
